load_unit: RTL
==============

# load_unit

Memory-read (load) engine for the datapath. It takes a load request, issues one word-aligned read to the synchronous data memory, and waits a fixed latency. It then extracts and extends the addressed byte, halfword or word, and delivers the result as a `Dout`/`WE` pair that drives a 32-bit write-enabled `register` directly. It is the read-side counterpart of the register write path: it produces the `Data`/`WE` that a register consumes.

## Interface
Parameters:
- `LATENCY`, default 2: cycles from the `MemRE` cycle to the cycle in which `MemData` is valid. Legal range is 1..15.

Ports:
- `CLK`  in  1  clock; all state changes on its rising edge.
- `RST_n`  in  1  reset, synchronous, active-low.
- `Req`  in  1  load request; sampled only in IDLE.
- `Addr`  in  32  byte address of the load.
- `Size`  in  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = reserved (illegal).
- `Unsigned`  in  1  1 = zero-extend, 0 = sign-extend. Ignored for word loads.
- `Busy`  out  1  high whenever the state is not IDLE.
- `MemRE`  out  1  memory read strobe; a one-cycle pulse.
- `MemAddr`  out  32  word address, equal to `{Addr[31:2],2'b00}`; held from issue until return to IDLE.
- `MemData`  in  32  memory read data; valid only in the last WAIT cycle.
- `Dout`  out  32 (signed)  load result; holds its last value between loads.
- `WE`  out  1  one-cycle write pulse, qualifying `Dout`.
- `Err`  out  1  one-cycle pulse flagging an illegal or misaligned request.

## Operation
- States are IDLE, ISSUE, WAIT, DONE and ERR. The state is held in a register; a down-counter sized for `LATENCY` runs during WAIT.
- **IDLE:**
  - On `Req`=1, latch `Addr[1:0]`, `Size` and `Unsigned`.
  - Legal request: load `MemAddr` and go to ISSUE.
  - Illegal request: go to ERR. Illegal means `Size`=11, halfword with `Addr[0]`=1, or word with `Addr[1:0]`≠00.
- **ISSUE:** `MemRE`=1 for exactly this cycle. Load the counter with `LATENCY`-1, then go to WAIT.
- **WAIT:** lasts exactly `LATENCY` cycles. On the last WAIT cycle's edge, capture the extracted value into `Dout`, then go to DONE.
- **DONE:** `WE`=1 for this cycle only, then go to IDLE. `Req` is ignored here.
- **ERR:** `Err`=1 for one cycle, then go to IDLE. `MemRE` is never asserted, `WE` stays 0 and `Dout` is unchanged.
- **Extraction (little-endian; byte lane n is `MemData[8n+7:8n]`):**
  - Byte: lane `Addr[1:0]`.
  - Halfword: `Addr[1]`=0 selects `MemData[15:0]`; `Addr[1]`=1 selects `MemData[31:16]`.
  - Word: all 32 bits.
  - Extension to 32 bits uses the sign of the selected MSB unless `Unsigned`=1.
- **Reset** (`RST_n`=0 at an edge), from any state including mid-WAIT:
  - State goes to IDLE and the counter is cleared.
  - `Dout`, `MemAddr`, `MemRE`, `WE`, `Err` and `Busy` all go to 0.
  - An outstanding read is abandoned: its `MemData` is never captured and no `WE` is produced.
- Reset has priority over `Req`.

## Timing
- Numbering: `Req` is accepted at edge 0, and cycle k is the cycle following edge k-1.
- Legal load:
  - Cycle 1: ISSUE, `MemRE`=1.
  - Cycles 2..1+`LATENCY`: WAIT. `MemData` is sampled at the end of cycle 1+`LATENCY`.
  - Cycle 2+`LATENCY`: DONE, `WE`=1 with the new `Dout`.
  - Cycle 3+`LATENCY`: IDLE. A `Req` present here is accepted.
  - Throughput is one load per `LATENCY`+3 cycles.
- Illegal load: cycle 1 is ERR with `Err`=1; cycle 2 is IDLE.
- `Busy` is 1 in every non-IDLE cycle and 0 in IDLE.
- `Dout` changes only at the edge entering DONE.
- `WE` and `Err` are never high in the same cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** hold `RST_n`=0 for 2 cycles with `Req`=1 → all outputs are 0 and the block stays in IDLE. Release → a request is accepted at the next edge.
- **Word load:** `LATENCY`=2, LW with `Addr`=0x0000_0107 & ~3 = 0x0000_0104, `MemData`=0xDEAD_BEEF →
  - `MemRE`=1 only in cycle 1, with `MemAddr`=0x0000_0104.
  - `WE`=1 only in cycle 4, with `Dout`=0xDEAD_BEEF.
  - `Busy`=1 in cycles 1–4.
- **Byte loads:** `MemData`=0x80FF_1234.
  - LB at 0x103 → 0xFFFF_FF80; LBU at 0x103 → 0x0000_0080.
  - LB at 0x100 → 0x0000_0034; LB at 0x102 → 0xFFFF_FFFF.
- **Halfword loads:** `MemData`=0x8001_7FFF.
  - LH at 0x102 → 0xFFFF_8001; LHU at 0x102 → 0x0000_8001; LH at 0x100 → 0x0000_7FFF.
- **Illegal requests:** LW at 0x102, LH at 0x101, and `Size`=11 →
  - `Err`=1 in cycle 1, then IDLE in cycle 2.
  - `MemRE` and `WE` are never asserted.
  - `Dout` keeps its prior value.
- **Reset and back-to-back:**
  - Assert `RST_n`=0 in the second WAIT cycle → no `WE`, `Dout`=0.
  - Separately, with `Req` held at 1 and `LATENCY`=1 → accepted loads produce `WE` pulses exactly 4 cycles apart; `Req` is ignored during DONE.

Source files
------------

// File: rtl/load_unit_if.sv
// rtl/load_unit_if.sv - request, memory and result signals of the load unit
//
// Purpose: bundles the load request, the synchronous data-memory read port
// and the register-write result of load_unit.
// Modports:
//   slave  - the load unit: takes Req/Addr/Size/Unsigned/MemData, drives
//            Busy/MemRE/MemAddr/Dout/WE/Err.
//   master - the surrounding datapath and memory: the opposite directions.
interface load_unit_if;
  logic               Req;
  logic [31:0]        Addr;
  logic [1:0]         Size;
  logic               Unsigned;
  logic               Busy;
  logic               MemRE;
  logic [31:0]        MemAddr;
  logic [31:0]        MemData;
  logic signed [31:0] Dout;
  logic               WE;
  logic               Err;

  modport slave (
    input  Req, Addr, Size, Unsigned, MemData,
    output Busy, MemRE, MemAddr, Dout, WE, Err
  );

  modport master (
    output Req, Addr, Size, Unsigned, MemData,
    input  Busy, MemRE, MemAddr, Dout, WE, Err
  );
endinterface

// File: rtl/load_unit.sv
// rtl/load_unit.sv - byte/halfword/word load engine with fixed memory latency
//
// Purpose: accepts one load request in IDLE, issues a single word-aligned
// read, waits LATENCY cycles for the memory data, extracts and extends the
// addressed byte/halfword/word and presents it as a Dout/WE register write.
// Misaligned or reserved-size requests produce a one-cycle Err pulse only.
// Ports:
//   CLK    - clock, all state changes on the rising edge
//   RST_n  - synchronous active-low reset
//   bus    - load_unit_if.slave (Req, Addr, Size, Unsigned, MemData in;
//            Busy, MemRE, MemAddr, Dout, WE, Err out)
// Parameter:
//   LATENCY - cycles from MemRE to valid MemData, 1..15
module load_unit #(
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST_n,
  load_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    ERR
  } state_t;

  // Four bits cover the whole 1..15 latency range.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  alo_q, alo_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] dout_q, dout_d;

  logic        illegal;
  logic [31:0] lane_shift;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ext;

  // Reserved size, odd halfword, or word not on a 4-byte boundary.
  always_comb begin
    illegal = 1'b0;
    case (bus.Size)
      2'b01:   illegal = bus.Addr[0];
      2'b10:   illegal = (bus.Addr[1:0] != 2'b00);
      2'b11:   illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  // Little-endian lane select driven by the latched low address bits.
  always_comb begin
    lane_shift = bus.MemData >> {alo_q, 3'b000};
    sel_byte   = lane_shift[7:0];
    sel_half   = alo_q[1] ? bus.MemData[31:16] : bus.MemData[15:0];
    case (size_q)
      2'b00:   ext = {{24{~uns_q & sel_byte[7]}}, sel_byte};
      2'b01:   ext = {{16{~uns_q & sel_half[15]}}, sel_half};
      default: ext = bus.MemData;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    alo_d   = alo_q;
    size_d  = size_q;
    uns_d   = uns_q;
    maddr_d = maddr_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (bus.Req) begin
          alo_d  = bus.Addr[1:0];
          size_d = bus.Size;
          uns_d  = bus.Unsigned;
          if (illegal) begin
            state_d = ERR;
          end else begin
            maddr_d = {bus.Addr[31:2], 2'b00};
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        // Counter reaching zero marks the cycle in which MemData is valid.
        if (cnt_q == 4'd0) begin
          dout_d  = ext;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      alo_q   <= 2'b00;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      maddr_q <= 32'd0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alo_q   <= alo_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      maddr_q <= maddr_d;
      dout_q  <= dout_d;
    end
  end

  // Strobes are pure decodes of the state register, so no input reaches
  // an output without passing through a flop.
  assign bus.Busy    = (state_q != IDLE);
  assign bus.MemRE   = (state_q == ISSUE);
  assign bus.WE      = (state_q == DONE);
  assign bus.Err     = (state_q == ERR);
  assign bus.MemAddr = maddr_q;
  assign bus.Dout    = dout_q;

endmodule
